// File: rtl/uart_fifo_core.sv
// uart_fifo_core: single-clock UART with runtime divisor/parity/stop, 16x majority-vote RX and TX/RX FIFOs.
// Optional RX idle timeout is compiled in when UART_RX_TIMEOUT_EN is defined.
module uart_fifo_core #(
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_TX_FIFO_DEPTH   = 16,
    parameter int P_RX_FIFO_DEPTH   = 16,
    parameter int P_DIV_WIDTH       = 16,
    parameter int P_TIMEOUT_CHARS   = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [P_DIV_WIDTH-1:0]               i_cfg_div,
    input  logic [1:0]                           i_cfg_parity,
    input  logic                                 i_cfg_stop2,
    input  logic                                 i_uart_rx,
    output logic                                 o_uart_tx,
    input  logic [P_UART_DATA_WIDTH-1:0]         i_user_tx_data,
    input  logic                                 i_user_tx_valid,
    output logic                                 o_user_tx_ready,
    output logic [P_UART_DATA_WIDTH-1:0]         o_user_rx_data,
    output logic [1:0]                           o_user_rx_err,
    output logic                                 o_user_rx_valid,
    input  logic                                 i_user_rx_ready,
    output logic                                 o_rx_overflow,
    output logic [$clog2(P_TX_FIFO_DEPTH):0]     o_tx_level,
    output logic [$clog2(P_RX_FIFO_DEPTH):0]     o_rx_level,
    output logic                                 o_rx_timeout
);
    localparam int N   = P_UART_DATA_WIDTH;
    localparam int TAW = $clog2(P_TX_FIFO_DEPTH);
    localparam int RAW = $clog2(P_RX_FIFO_DEPTH);
    localparam logic [TAW:0]         TX_FULL_LVL = (TAW+1)'(P_TX_FIFO_DEPTH);
    localparam logic [RAW:0]         RX_FULL_LVL = (RAW+1)'(P_RX_FIFO_DEPTH);
    localparam logic [3:0]           BIT_LAST    = 4'(P_UART_DATA_WIDTH - 1);
    localparam logic [P_DIV_WIDTH-1:0] DIV_ONE   = 1;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Free-running oversample tick; ">=" keeps it safe when the divisor shrinks at runtime.
    logic [P_DIV_WIDTH-1:0] div_cnt_reg, div_last;
    logic                   tick;
    assign div_last = (i_cfg_div == '0) ? '0 : i_cfg_div - DIV_ONE;
    assign tick     = (div_cnt_reg >= div_last);

    always_ff @(posedge clock or negedge reset)
        if (!reset)    div_cnt_reg <= '0;
        else if (tick) div_cnt_reg <= '0;
        else           div_cnt_reg <= div_cnt_reg + DIV_ONE;

    // ---------------- TX FIFO ----------------
    logic [N-1:0] tx_mem [P_TX_FIFO_DEPTH];
    logic [TAW:0] tx_wr_ptr_reg, tx_rd_ptr_reg, tx_level;
    logic         tx_empty, tx_full, tx_push, tx_pop;
    assign tx_level        = tx_wr_ptr_reg - tx_rd_ptr_reg;
    assign tx_empty        = (tx_level == '0);
    assign tx_full         = (tx_level == TX_FULL_LVL);
    assign o_user_tx_ready = !tx_full || tx_pop;
    assign tx_push         = i_user_tx_valid && o_user_tx_ready;
    assign o_tx_level      = tx_level;

    always_ff @(posedge clock)
        if (tx_push) tx_mem[tx_wr_ptr_reg[TAW-1:0]] <= i_user_tx_data;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            tx_wr_ptr_reg <= '0;
            tx_rd_ptr_reg <= '0;
        end else begin
            if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
        end

    // ---------------- TX FSM ----------------
    tx_state_t    tx_state_reg, tx_state_next;
    logic [N-1:0] tx_shift_reg;
    logic [4:0]   tx_tick_reg;
    logic [3:0]   tx_bit_reg;
    logic         tx_par_en_reg, tx_par_bit_reg, tx_stop2_reg, tx_bit_end;
    assign tx_bit_end = tick && (tx_tick_reg ==
                        ((tx_state_reg == TX_STOP && tx_stop2_reg) ? 5'd31 : 5'd15));

    always_ff @(posedge clock or negedge reset)
        if (!reset) tx_state_reg <= TX_IDLE;
        else        tx_state_reg <= tx_state_next;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_pop        = 1'b0;
        case (tx_state_reg)
            TX_IDLE:   if (tick && !tx_empty) begin
                           tx_pop        = 1'b1;
                           tx_state_next = TX_START;
                       end
            TX_START:  if (tx_bit_end) tx_state_next = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bit_reg == BIT_LAST)
                           tx_state_next = tx_par_en_reg ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_state_next = TX_STOP;
            TX_STOP:   if (tx_bit_end) begin
                           // Back-to-back frames: next start bit follows the stop bit directly.
                           tx_pop        = !tx_empty;
                           tx_state_next = tx_empty ? TX_IDLE : TX_START;
                       end
            default:   tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        o_uart_tx = 1'b1;
        case (tx_state_reg)
            TX_START:  o_uart_tx = 1'b0;
            TX_DATA:   o_uart_tx = tx_shift_reg[0];
            TX_PARITY: o_uart_tx = tx_par_bit_reg;
            default:   o_uart_tx = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            tx_shift_reg   <= '0;
            tx_tick_reg    <= '0;
            tx_bit_reg     <= '0;
            tx_par_en_reg  <= 1'b0;
            tx_par_bit_reg <= 1'b0;
            tx_stop2_reg   <= 1'b0;
        end else if (tx_pop) begin
            tx_shift_reg   <= tx_mem[tx_rd_ptr_reg[TAW-1:0]];
            tx_par_en_reg  <= (i_cfg_parity == 2'd1) || (i_cfg_parity == 2'd2);
            tx_par_bit_reg <= (^tx_mem[tx_rd_ptr_reg[TAW-1:0]]) ^ (i_cfg_parity == 2'd1);
            tx_stop2_reg   <= i_cfg_stop2;
            tx_tick_reg    <= '0;
        end else if (tick) begin
            if (tx_bit_end) begin
                tx_tick_reg <= '0;
                if (tx_state_reg == TX_START) tx_bit_reg <= '0;
                if (tx_state_reg == TX_DATA) begin
                    tx_shift_reg <= tx_shift_reg >> 1;
                    tx_bit_reg   <= tx_bit_reg + 4'd1;
                end
            end else begin
                tx_tick_reg <= tx_tick_reg + 5'd1;
            end
        end

    // ---------------- RX front end and FSM ----------------
    logic [1:0]   rx_sync_reg;
    logic         rx_prev_reg, rx_line, rx_fall, rx_maj, rx_mid, rx_end;
    logic         rx_s7_reg, rx_s8_reg, rx_par_en_reg, rx_par_odd_reg, rx_par_bit_reg;
    logic [3:0]   rx_tick_reg, rx_bit_reg;
    logic [N-1:0] rx_shift_reg;
    logic         rx_start, rx_wr_req;
    rx_state_t    rx_state_reg, rx_state_next;
    assign rx_line = rx_sync_reg[1];
    assign rx_fall = rx_prev_reg && !rx_line;
    assign rx_maj  = (rx_s7_reg & rx_s8_reg) | (rx_s7_reg & rx_line) | (rx_s8_reg & rx_line);
    assign rx_mid  = tick && (rx_tick_reg == 4'd9);
    assign rx_end  = tick && (rx_tick_reg == 4'd15);

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rx_sync_reg  <= 2'b11;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= RX_IDLE;
        end else begin
            rx_sync_reg  <= {rx_sync_reg[0], i_uart_rx};
            rx_prev_reg  <= rx_line;
            rx_state_reg <= rx_state_next;
        end

    // A held-low line (break) never yields a new falling edge, so RX waits for the line to recover.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_start      = 1'b0;
        rx_wr_req     = 1'b0;
        case (rx_state_reg)
            RX_IDLE:   if (rx_fall) begin
                           rx_start      = 1'b1;
                           rx_state_next = RX_START;
                       end
            RX_START:  if (rx_mid && rx_maj) rx_state_next = RX_IDLE;
                       else if (rx_end)      rx_state_next = RX_DATA;
            RX_DATA:   if (rx_end && rx_bit_reg == BIT_LAST)
                           rx_state_next = rx_par_en_reg ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_end) rx_state_next = RX_STOP;
            RX_STOP:   if (rx_mid) begin
                           rx_wr_req     = 1'b1;
                           rx_state_next = RX_IDLE;
                       end
            default:   rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rx_tick_reg    <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_s7_reg      <= 1'b1;
            rx_s8_reg      <= 1'b1;
            rx_par_en_reg  <= 1'b0;
            rx_par_odd_reg <= 1'b0;
            rx_par_bit_reg <= 1'b0;
        end else if (rx_start) begin
            rx_tick_reg    <= '0;
            rx_par_en_reg  <= (i_cfg_parity == 2'd1) || (i_cfg_parity == 2'd2);
            rx_par_odd_reg <= (i_cfg_parity == 2'd1);
        end else if (tick) begin
            rx_tick_reg <= rx_tick_reg + 4'd1;
            if (rx_tick_reg == 4'd7) rx_s7_reg <= rx_line;
            if (rx_tick_reg == 4'd8) rx_s8_reg <= rx_line;
            if (rx_mid && rx_state_reg == RX_DATA)   rx_shift_reg   <= {rx_maj, rx_shift_reg[N-1:1]};
            if (rx_mid && rx_state_reg == RX_PARITY) rx_par_bit_reg <= rx_maj;
            if (rx_end && rx_state_reg == RX_START)  rx_bit_reg     <= '0;
            if (rx_end && rx_state_reg == RX_DATA)   rx_bit_reg     <= rx_bit_reg + 4'd1;
        end

    // ---------------- RX FIFO ----------------
    logic [N+1:0] rx_mem [P_RX_FIFO_DEPTH];
    logic [N+1:0] rx_word, rx_head;
    logic [RAW:0] rx_wr_ptr_reg, rx_rd_ptr_reg, rx_level;
    logic         rx_full, rx_push, rx_pop, rx_ovf_reg;
    assign rx_word = {rx_par_en_reg && (^rx_shift_reg ^ rx_par_bit_reg ^ rx_par_odd_reg),
                      !rx_maj, rx_shift_reg};
    assign rx_level        = rx_wr_ptr_reg - rx_rd_ptr_reg;
    assign rx_full         = (rx_level == RX_FULL_LVL);
    assign o_user_rx_valid = (rx_level != '0);
    assign rx_pop          = o_user_rx_valid && i_user_rx_ready;
    assign rx_push         = rx_wr_req && (!rx_full || rx_pop);
    assign rx_head         = rx_mem[rx_rd_ptr_reg[RAW-1:0]];
    assign o_user_rx_data  = o_user_rx_valid ? rx_head[N-1:0] : '0;
    assign o_user_rx_err   = o_user_rx_valid ? rx_head[N+1:N] : 2'b00;
    assign o_rx_level      = rx_level;
    assign o_rx_overflow   = rx_ovf_reg;

    always_ff @(posedge clock)
        if (rx_push) rx_mem[rx_wr_ptr_reg[RAW-1:0]] <= rx_word;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            rx_wr_ptr_reg <= '0;
            rx_rd_ptr_reg <= '0;
            rx_ovf_reg    <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            rx_ovf_reg <= rx_wr_req && !rx_push;
        end

`ifdef UART_RX_TIMEOUT_EN
    // Fires once per write burst: armed by a write, disarmed when it fires.
    logic [31:0] to_cnt_reg, to_limit;
    logic        to_armed_reg, to_pulse_reg, cfg_par_en;
    assign cfg_par_en = (i_cfg_parity == 2'd1) || (i_cfg_parity == 2'd2);
    assign to_limit   = 32'(P_TIMEOUT_CHARS) * (32'(N + 2) + 32'(cfg_par_en) + 32'(i_cfg_stop2)) * 32'd16;

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            to_cnt_reg   <= '0;
            to_armed_reg <= 1'b0;
            to_pulse_reg <= 1'b0;
        end else begin
            to_pulse_reg <= 1'b0;
            if (rx_push) begin
                to_cnt_reg   <= '0;
                to_armed_reg <= 1'b1;
            end else if (rx_start || rx_pop) begin
                to_cnt_reg <= '0;
            end else if (tick && to_armed_reg && rx_level != '0) begin
                if (to_cnt_reg == to_limit - 32'd1) begin
                    to_pulse_reg <= 1'b1;
                    to_armed_reg <= 1'b0;
                    to_cnt_reg   <= '0;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 32'd1;
                end
            end
        end
    assign o_rx_timeout = to_pulse_reg;
`else
    assign o_rx_timeout = 1'b0;
`endif
endmodule
